debug_rx_loader: RTL

//  Receiving end of the PC->board debug link: consumes bytes from the UART RX (valid/data),

---
 rtl/debug_rx_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/debug_rx_loader.sv
// debug_rx_loader: receiving end of the PC->board debug link.
// Assembles 32-bit program words from UART bytes (LSB byte first) and writes
// them into program memory from address 0 until a halt word or a full memory.
// After loading, it decodes single-byte commands into CPU run/step controls.
// Optional feature: define DEBUG_RX_RELOAD_EN so that byte 'l' in CMD or DONE
// restarts the load phase without a reset.
module debug_rx_loader #(
   parameter int NB_DATA       = 32,
   parameter int NB_RX         = 8,
   parameter int N_P_MEM_ADDR  = 128,
   parameter int NB_P_MEM_ADDR = $clog2(N_P_MEM_ADDR),
   parameter int HALT_BIT      = 30
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [NB_RX-1:0]         i_rx_data,
   input  logic                     i_rx_valid,
   input  logic                     i_cpu_halted,
   output logic                     o_pmem_wr_en,
   output logic [NB_P_MEM_ADDR-1:0] o_pmem_addr,
   output logic [NB_DATA-1:0]       o_pmem_wr_data,
   output logic                     o_load_done,
   output logic                     o_load_ovf,
   output logic                     o_cpu_run,
   output logic                     o_cpu_step,
   output logic [2:0]               o_state
);

   typedef enum logic [2:0] {
      LOAD = 3'd0,
      CMD  = 3'd1,
      RUN  = 3'd2,
      STEP = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam logic [NB_RX-1:0]         CH_C      = NB_RX'(8'h63);
   localparam logic [NB_RX-1:0]         CH_S      = NB_RX'(8'h73);
   localparam logic [NB_RX-1:0]         CH_NL     = NB_RX'(8'h0A);
   localparam logic [NB_P_MEM_ADDR-1:0] LAST_ADDR = NB_P_MEM_ADDR'(N_P_MEM_ADDR - 1);

   state_t                   state, state_n;
   logic [1:0]               byte_cnt, byte_cnt_n;
   logic [NB_DATA-1:0]       word, word_n, shifted;
   logic [NB_P_MEM_ADDR-1:0] addr, addr_n;
   logic                     wr_en_n;
   logic [NB_P_MEM_ADDR-1:0] wr_addr_n;
   logic [NB_DATA-1:0]       wr_data_n;
   logic                     load_done_n, load_ovf_n;
   logic                     cpu_run_n, cpu_step_n;
   logic                     reload_hit;

`ifdef DEBUG_RX_RELOAD_EN
   localparam logic [NB_RX-1:0] CH_L = NB_RX'(8'h6C);
   assign reload_hit = i_rx_valid && (i_rx_data == CH_L) && ((state == CMD) || (state == DONE));
`else
   assign reload_hit = 1'b0;
`endif

   assign o_state = state;

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_n     = state;
      byte_cnt_n  = byte_cnt;
      word_n      = word;
      addr_n      = addr;
      wr_en_n     = 1'b0;
      wr_addr_n   = o_pmem_addr;
      wr_data_n   = o_pmem_wr_data;
      load_done_n = o_load_done;
      load_ovf_n  = o_load_ovf;
      cpu_run_n   = o_cpu_run;
      cpu_step_n  = 1'b0;
      shifted     = {i_rx_data, word[NB_DATA-1:NB_RX]};

      case (state)
         LOAD: begin
            if (i_rx_valid) begin
               word_n = shifted;
               if (byte_cnt == 2'd3) begin
                  byte_cnt_n = 2'd0;
                  wr_en_n    = 1'b1;
                  wr_addr_n  = addr;
                  wr_data_n  = shifted;
                  if (addr != LAST_ADDR) begin
                     addr_n = addr + 1'b1;
                  end
                  if (shifted[HALT_BIT]) begin
                     state_n     = CMD;
                     load_done_n = 1'b1;
                  end else if (addr == LAST_ADDR) begin
                     state_n     = CMD;
                     load_done_n = 1'b1;
                     load_ovf_n  = 1'b1;
                  end
               end else begin
                  byte_cnt_n = byte_cnt + 2'd1;
               end
            end
         end
         CMD: begin
            if (i_rx_valid && (i_rx_data == CH_C)) begin
               state_n   = RUN;
               cpu_run_n = 1'b1;
            end else if (i_rx_valid && (i_rx_data == CH_S)) begin
               state_n = STEP;
            end
         end
         RUN: begin
            if (i_cpu_halted) begin
               state_n   = DONE;
               cpu_run_n = 1'b0;
            end
         end
         STEP: begin
            if (i_cpu_halted) begin
               state_n = DONE;
            end else if (i_rx_valid && (i_rx_data == CH_NL)) begin
               cpu_step_n = 1'b1;
            end else if (i_rx_valid && (i_rx_data == CH_C)) begin
               state_n   = RUN;
               cpu_run_n = 1'b1;
            end
         end
         DONE: begin
            cpu_run_n = 1'b0;
         end
         default: begin
            state_n   = LOAD;
            cpu_run_n = 1'b0;
         end
      endcase

      if (reload_hit) begin
         state_n     = LOAD;
         addr_n      = '0;
         byte_cnt_n  = 2'd0;
         word_n      = '0;
         load_done_n = 1'b0;
         load_ovf_n  = 1'b0;
         cpu_run_n   = 1'b0;
      end
   end

   // State, assembly and output registers; reset drops any partial word.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state          <= LOAD;
         byte_cnt       <= 2'd0;
         word           <= '0;
         addr           <= '0;
         o_pmem_wr_en   <= 1'b0;
         o_pmem_addr    <= '0;
         o_pmem_wr_data <= '0;
         o_load_done    <= 1'b0;
         o_load_ovf     <= 1'b0;
         o_cpu_run      <= 1'b0;
         o_cpu_step     <= 1'b0;
      end else begin
         state          <= state_n;
         byte_cnt       <= byte_cnt_n;
         word           <= word_n;
         addr           <= addr_n;
         o_pmem_wr_en   <= wr_en_n;
         o_pmem_addr    <= wr_addr_n;
         o_pmem_wr_data <= wr_data_n;
         o_load_done    <= load_done_n;
         o_load_ovf     <= load_ovf_n;
         o_cpu_run      <= cpu_run_n;
         o_cpu_step     <= cpu_step_n;
      end
   end

endmodule
